// File: rtl/murmur_lanes_part.sv
// Multi-lane MurmurHash3 fmix64 hasher for the partitioned hash join.
// Each lane is a 5-stage pipeline that carries tuple, last and serial number
// next to the hash. The lane holds completely while its output is stalled.
// Per-lane emitted-tuple counters saturate. all_done is sticky and rises
// once every lane has emitted a last-flagged tuple.
module murmur_lanes_part #(
    parameter int          NUM_LANES = 8,
    parameter int          TUPLE_W   = 64,
    parameter int          KEY_W     = 64,
    parameter int          SERIAL_W  = 64,
    parameter int          PART_BITS = 10,
    parameter logic [63:0] SEED      = 64'h0,
    parameter int          CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           in_valid,
    output logic [NUM_LANES-1:0]           in_ready,
    input  logic [NUM_LANES*TUPLE_W-1:0]   in_data,
    input  logic [NUM_LANES-1:0]           in_last,
    input  logic [NUM_LANES*SERIAL_W-1:0]  in_serialnum,
    output logic [NUM_LANES-1:0]           out_valid,
    input  logic [NUM_LANES-1:0]           out_ready,
    output logic [NUM_LANES*TUPLE_W-1:0]   out_tuple,
    output logic [NUM_LANES*32-1:0]        out_tag,
    output logic [NUM_LANES*PART_BITS-1:0] out_part,
    output logic [NUM_LANES-1:0]           out_last,
    output logic [NUM_LANES*SERIAL_W-1:0]  out_serialnum,
    output logic [NUM_LANES*CNT_W-1:0]     out_count,
    output logic                           all_done
);
    localparam logic [63:0]      MUL1    = 64'hff51afd7ed558ccd;
    localparam logic [63:0]      MUL2    = 64'hc4ceb53ca5ed1a85;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam int               STAGES  = 5;

    function automatic logic [63:0] xor_shift33(input logic [63:0] v);
        return v ^ (v >> 6'd33);
    endfunction

    logic [NUM_LANES-1:0] done_set_s;
    logic [NUM_LANES-1:0] done_next_s;
    logic [NUM_LANES-1:0] done_lane_r;
    logic                 all_done_r;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [STAGES-1:0]   vld_r;
        logic [STAGES-1:0]   last_r;
        logic [63:0]         hash_r [STAGES];
        logic [TUPLE_W-1:0]  tup_r  [STAGES];
        logic [SERIAL_W-1:0] ser_r  [STAGES];
        logic [CNT_W-1:0]    cnt_r;
        logic                en_s;
        logic                out_xfer_s;
        logic [63:0]         key_s;

        // A stalled lane freezes every stage, bubbles included.
        assign en_s       = ~vld_r[STAGES-1] | out_ready[i];
        assign out_xfer_s = vld_r[STAGES-1] & out_ready[i];
        assign key_s      = 64'(in_data[i*TUPLE_W +: KEY_W]) ^ SEED;

        // Stage valids and last flags: the only pipeline state cleared by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_r  <= {STAGES{1'b0}};
                last_r <= {STAGES{1'b0}};
            end else if (en_s) begin
                vld_r  <= {vld_r[STAGES-2:0], in_valid[i]};
                last_r <= {last_r[STAGES-2:0], in_valid[i] & in_last[i]};
            end
        end

        // Hash datapath plus sideband shift registers, advanced when the lane is enabled.
        always_ff @(posedge clk) begin
            if (en_s) begin
                hash_r[0] <= xor_shift33(key_s);
                hash_r[1] <= hash_r[0] * MUL1;
                hash_r[2] <= xor_shift33(hash_r[1]);
                hash_r[3] <= hash_r[2] * MUL2;
                hash_r[4] <= xor_shift33(hash_r[3]);
                tup_r[0]  <= in_data[i*TUPLE_W +: TUPLE_W];
                ser_r[0]  <= in_serialnum[i*SERIAL_W +: SERIAL_W];
                for (int s = 1; s < STAGES; s++) begin
                    tup_r[s] <= tup_r[s-1];
                    ser_r[s] <= ser_r[s-1];
                end
            end
        end

        // Saturating count of output transfers.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (out_xfer_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end

        assign done_set_s[i]                           = out_xfer_s & last_r[STAGES-1];
        assign in_ready[i]                             = en_s;
        assign out_valid[i]                            = vld_r[STAGES-1];
        assign out_last[i]                             = last_r[STAGES-1];
        assign out_tuple[i*TUPLE_W +: TUPLE_W]         = tup_r[STAGES-1];
        assign out_serialnum[i*SERIAL_W +: SERIAL_W]   = ser_r[STAGES-1];
        assign out_tag[i*32 +: 32]                     = hash_r[STAGES-1][63:32];
        assign out_part[i*PART_BITS +: PART_BITS]      = hash_r[STAGES-1][PART_BITS-1:0];
        assign out_count[i*CNT_W +: CNT_W]             = cnt_r;
    end

    assign done_next_s = done_lane_r | done_set_s;

    // Sticky per-lane done flags; all_done includes this cycle's final transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_lane_r <= {NUM_LANES{1'b0}};
            all_done_r  <= 1'b0;
        end else begin
            done_lane_r <= done_next_s;
            all_done_r  <= &done_next_s;
        end
    end

    assign all_done = all_done_r;
endmodule

// File: tb/tb_murmur_lanes_part.sv
// Directed bench for murmur_lanes_part: an 8-lane unseeded instance with a
// scoreboard, plus a 2-lane seeded instance with a 3-bit counter.
module tb_murmur_lanes_part;
    localparam int NL = 8;

    logic clk = 1'b0;
    logic reset;
    logic [NL-1:0]    in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [NL*64-1:0] in_data, in_serialnum, out_tuple, out_serialnum;
    logic [NL*32-1:0] out_tag, out_count;
    logic [NL*10-1:0] out_part;
    logic             all_done;

    logic [1:0]   b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
    logic [127:0] b_in_data, b_in_serialnum, b_out_tuple, b_out_serialnum;
    logic [63:0]  b_out_tag;
    logic [19:0]  b_out_part;
    logic [5:0]   b_out_count;
    logic         b_all_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    murmur_lanes_part #(.NUM_LANES(NL), .TUPLE_W(64), .KEY_W(64), .SERIAL_W(64),
                        .PART_BITS(10), .SEED(64'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_serialnum(in_serialnum),
        .out_valid(out_valid), .out_ready(out_ready), .out_tuple(out_tuple),
        .out_tag(out_tag), .out_part(out_part), .out_last(out_last),
        .out_serialnum(out_serialnum), .out_count(out_count), .all_done(all_done));

    murmur_lanes_part #(.NUM_LANES(2), .TUPLE_W(64), .KEY_W(64), .SERIAL_W(64),
                        .PART_BITS(10), .SEED(64'h1234), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .in_serialnum(b_in_serialnum),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tuple(b_out_tuple),
        .out_tag(b_out_tag), .out_part(b_out_part), .out_last(b_out_last),
        .out_serialnum(b_out_serialnum), .out_count(b_out_count), .all_done(b_all_done));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Software fmix64 reference using a full 128-bit product.
    function automatic logic [63:0] fmix_model(input logic [63:0] key, input logic [63:0] seed);
        logic [127:0] p;
        logic [63:0]  h;
        h = key ^ seed;
        h = h ^ (h >> 33);
        p = 128'(h) * 128'hff51afd7ed558ccd;
        h = p[63:0];
        h = h ^ (h >> 33);
        p = 128'(h) * 128'hc4ceb53ca5ed1a85;
        h = p[63:0];
        return h ^ (h >> 33);
    endfunction

    // Scoreboard and cycle model state for the 8-lane instance.
    logic [63:0] exp_tup [NL][32];
    logic [63:0] exp_ser [NL][32];
    logic [63:0] exp_hsh [NL][32];
    logic        exp_lst [NL][32];
    int          wp [NL];
    int          rp [NL];
    logic [31:0] cnt_m [NL];
    logic [NL-1:0] done_m = '0;
    logic        all_done_m = 1'b0;
    logic [NL-1:0] stall_p = '0;
    logic [63:0] tup_p [NL];
    logic [31:0] tag_p [NL];
    bit          mon_en = 1'b0;

    // Stimulus configuration for the multi-lane stream driver.
    logic [63:0] mem_data [NL][24];
    int          n_send [NL];
    int          start_cyc [NL];
    int          idx [NL];
    bit          last_on [NL];
    bit          rand_rdy [NL];
    logic [63:0] gold [4];
    logic [63:0] keys_b [10];

    // Monitor: compares counters, done flag, held outputs and emitted tuples each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("all_done", 64'(all_done), 64'(all_done_m));
            for (int l = 0; l < NL; l++) begin
                check("count", 64'(out_count[l*32 +: 32]), 64'(cnt_m[l]));
                if (stall_p[l]) begin
                    check("hold_valid", 64'(out_valid[l]), 64'(1'b1));
                    check("hold_tuple", out_tuple[l*64 +: 64], tup_p[l]);
                    check("hold_tag", 64'(out_tag[l*32 +: 32]), 64'(tag_p[l]));
                end
            end
            if (reset) begin
                for (int l = 0; l < NL; l++) begin
                    wp[l] = 0; rp[l] = 0; cnt_m[l] = 32'd0;
                end
                done_m = '0; all_done_m = 1'b0; stall_p = '0;
            end else begin
                for (int l = 0; l < NL; l++) begin
                    if (out_valid[l] && out_ready[l]) begin
                        if (rp[l] == wp[l]) begin
                            check("spurious_out", 64'(out_valid[l]), 64'(1'b0));
                        end else begin
                            check("out_tuple", out_tuple[l*64 +: 64], exp_tup[l][rp[l]%32]);
                            check("out_serial", out_serialnum[l*64 +: 64], exp_ser[l][rp[l]%32]);
                            check("out_tag", 64'(out_tag[l*32 +: 32]), 64'(exp_hsh[l][rp[l]%32][63:32]));
                            check("out_part", 64'(out_part[l*10 +: 10]), 64'(exp_hsh[l][rp[l]%32][9:0]));
                            check("out_last", 64'(out_last[l]), 64'(exp_lst[l][rp[l]%32]));
                            rp[l]++;
                        end
                        if (cnt_m[l] != 32'hFFFF_FFFF) cnt_m[l] = cnt_m[l] + 32'd1;
                        if (out_last[l]) done_m[l] = 1'b1;
                    end
                    if (in_valid[l] && in_ready[l]) begin
                        exp_tup[l][wp[l]%32] = in_data[l*64 +: 64];
                        exp_ser[l][wp[l]%32] = in_serialnum[l*64 +: 64];
                        exp_hsh[l][wp[l]%32] = fmix_model(in_data[l*64 +: 64], 64'h0);
                        exp_lst[l][wp[l]%32] = in_last[l];
                        wp[l]++;
                    end
                    stall_p[l] = out_valid[l] && !out_ready[l];
                    tup_p[l]   = out_tuple[l*64 +: 64];
                    tag_p[l]   = out_tag[l*32 +: 32];
                end
                all_done_m = &done_m;
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = '0; in_last = '0; out_ready = '1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int l = 0; l < NL; l++) begin
            n_send[l] = 0; start_cyc[l] = 0; idx[l] = 0; last_on[l] = 1'b0; rand_rdy[l] = 1'b0;
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        in_valid = '0; in_last = '0; out_ready = '1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Cycle-based driver: feeds every configured lane, optionally stalling its output.
    task automatic run_streams(input int budget);
        int cyc;
        bit busy;
        cyc = 0; busy = 1'b1;
        while (busy && cyc < budget) begin
            @(posedge clk); #1;
            for (int l = 0; l < NL; l++) begin
                if (cyc >= start_cyc[l] && idx[l] < n_send[l]) begin
                    in_valid[l] = 1'b1;
                    in_data[l*64 +: 64] = mem_data[l][idx[l]];
                    in_last[l] = last_on[l] && (idx[l] == n_send[l] - 1);
                    in_serialnum[l*64 +: 64] = 64'(l * 256 + idx[l]);
                end else begin
                    in_valid[l] = 1'b0;
                    in_last[l] = 1'b0;
                end
                out_ready[l] = rand_rdy[l] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk); #1;
            busy = 1'b0;
            for (int l = 0; l < NL; l++) begin
                if (!rand_rdy[l] && in_valid[l]) check("full_rate_ready", 64'(in_ready[l]), 64'(1'b1));
                if (in_valid[l] && in_ready[l]) idx[l]++;
                if (idx[l] < n_send[l] || wp[l] != rp[l]) busy = 1'b1;
            end
            cyc++;
        end
        check("stream_budget", 64'(busy), 64'(1'b0));
        drain();
    endtask

    // Single tuple on an idle lane: exact 5-cycle latency and first count.
    task automatic send_one_latency(input int l, input logic [63:0] d, input logic [63:0] s,
                                    input logic [31:0] etag, input logic [9:0] epart);
        @(posedge clk); #1;
        out_ready = '1;
        in_valid[l] = 1'b1; in_last[l] = 1'b0;
        in_data[l*64 +: 64] = d; in_serialnum[l*64 +: 64] = s;
        @(negedge clk);
        check("lat_accept", 64'(in_ready[l]), 64'(1'b1));
        @(posedge clk); #1;
        in_valid[l] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("lat_early", 64'(out_valid[l]), 64'(1'b0));
        end
        @(negedge clk);
        check("lat_valid", 64'(out_valid[l]), 64'(1'b1));
        check("lat_tag", 64'(out_tag[l*32 +: 32]), 64'(etag));
        check("lat_part", 64'(out_part[l*10 +: 10]), 64'(epart));
        check("lat_serial", out_serialnum[l*64 +: 64], s);
        @(negedge clk);
        check("lat_count", 64'(out_count[l*32 +: 32]), 64'(32'd1));
    endtask

    initial begin
        logic [63:0] hx;
        int j;
        reset = 1'b1;
        in_valid = '0; in_last = '0; in_data = '0; in_serialnum = '0; out_ready = '1;
        b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_in_serialnum = '0; b_out_ready = '1;
        gold[0] = 64'h1; gold[1] = 64'h8000_0000_0000_0000;
        gold[2] = 64'hDEAD_BEEF_CAFE_F00D; gold[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 4; k++) keys_b[k] = gold[k];
        keys_b[4] = 64'h0; keys_b[5] = 64'h1234; keys_b[6] = 64'h2;
        keys_b[7] = 64'h3; keys_b[8] = 64'h5; keys_b[9] = 64'h6;
        for (int l = 0; l < NL; l++) begin
            wp[l] = 0; rp[l] = 0; cnt_m[l] = 32'd0;
        end
        clear_cfg();

        // Reset state
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(8'h00));
        check("rst_last", 64'(out_last), 64'(8'h00));
        check("rst_all_done", 64'(all_done), 64'(1'b0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'(8'h00));

        // Zero key with seed 0 hashes to 0
        send_one_latency(0, 64'h0, 64'h7, 32'h0, 10'h0);
        drain();

        // Golden keys on every lane at full rate
        pulse_reset();
        clear_cfg();
        for (int l = 0; l < NL; l++) begin
            n_send[l] = 4;
            for (int k = 0; k < 4; k++) mem_data[l][k] = gold[(k + l) % 4];
        end
        run_streams(100);
        check("gold_count0", 64'(out_count[31:0]), 64'(32'd4));

        // Backpressure on lane 2 while lane 3 streams at full rate
        pulse_reset();
        clear_cfg();
        n_send[2] = 20; n_send[3] = 20; rand_rdy[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mem_data[2][k] = 64'h0200_0000_0000_0000 + 64'(k * 977);
            mem_data[3][k] = 64'h0300_0000_0000_0000 ^ 64'(k * 31337);
        end
        run_streams(400);
        check("bp_count2", 64'(out_count[2*32 +: 32]), 64'(32'd20));
        check("bp_count3", 64'(out_count[3*32 +: 32]), 64'(32'd20));

        // Done tracking with lane 5 finishing last
        pulse_reset();
        clear_cfg();
        for (int l = 0; l < NL; l++) begin
            n_send[l] = 4; last_on[l] = 1'b1;
            for (int k = 0; k < 4; k++) mem_data[l][k] = 64'(l * 16 + k);
        end
        start_cyc[5] = 12;
        run_streams(100);
        check("done_all", 64'(all_done), 64'(1'b1));
        for (int l = 0; l < NL; l++) check("done_count", 64'(out_count[l*32 +: 32]), 64'(32'd4));
        repeat (3) @(negedge clk);
        check("done_sticky", 64'(all_done), 64'(1'b1));

        // Reset with three tuples in flight on lane 0
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[63:0] = 64'hA0; in_serialnum[63:0] = 64'd100;
        @(posedge clk); #1 in_data[63:0] = 64'hA1; in_serialnum[63:0] = 64'd101;
        @(posedge clk); #1 in_data[63:0] = 64'hA2; in_serialnum[63:0] = 64'd102;
        @(posedge clk); #1 in_valid[0] = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        in_valid[1] = 1'b1; in_data[127:64] = 64'hBAD;
        @(posedge clk); #1 reset = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        check("mid_rst_count", 64'(out_count[31:0]), 64'(32'd0));
        check("mid_rst_all_done", 64'(all_done), 64'(1'b0));
        for (int c = 0; c < 8; c++) begin
            check("mid_rst_stale", 64'(out_valid), 64'(8'h00));
            @(negedge clk);
        end
        hx = fmix_model(64'hDEAD_BEEF_CAFE_F00D, 64'h0);
        send_one_latency(0, 64'hDEAD_BEEF_CAFE_F00D, 64'h55, hx[63:32], hx[9:0]);
        drain();

        // Seeded instance: golden keys with seed, counter saturation at 7
        pulse_reset();
        j = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (c < 10) begin
                b_in_valid[0] = 1'b1; b_in_data[63:0] = keys_b[c];
            end else begin
                b_in_valid[0] = 1'b0;
            end
            @(negedge clk);
            if (b_out_valid[0] && j < 10) begin
                hx = fmix_model(keys_b[j], 64'h1234);
                check("seed_tag", 64'(b_out_tag[31:0]), 64'(hx[63:32]));
                check("seed_part", 64'(b_out_part[9:0]), 64'(hx[9:0]));
                check("seed_tuple", b_out_tuple[63:0], keys_b[j]);
                if (j == 5) check("seed_cancel_tag", 64'(b_out_tag[31:0]), 64'(32'h0));
                j++;
            end
        end
        check("seed_outputs", 64'(j), 64'(10));
        check("sat_count", 64'(b_out_count[2:0]), 64'(3'd7));
        check("sat_idle_lane", 64'(b_out_count[5:3]), 64'(3'd0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
